sysbus_mem_responder: RTL and testbench

//   Memory-side responder (slave) for the 64-bit system bus: answers the line read/write bursts that the

---
 rtl/sysbus_mem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//   Memory-side responder for the 64-bit system bus. Stores DEPTH lines of
//   512 bits and serves one line read or line write burst at a time.
//
//   Build option: MEMRESP_CRITICAL_WORD_FIRST_EN
//     defined     - read bursts start at address bits [5:3] and wrap mod 8
//     not defined - read bursts always start at word 0
//   Write bursts are line aligned (word 0 first) in both builds.
//
//   Bus handshake (both directions are registered on this side):
//     request  : the initiator holds bus_reqcyc with a beat on bus_req until
//                it sees the one-cycle bus_reqack pulse; the beat is taken on
//                the edge that raises bus_reqack. Beat 0 is the address (with
//                bus_reqtag), beats 1..8 carry write data for write tags.
//     response : bus_respcyc/bus_resp/bus_resptag stay stable until
//                bus_respack is sampled high, then the next beat follows.
//
//   Line index = address bits [6 +: log2(DEPTH)]; upper address bits alias.
//   The current FSM state is visible through the state register and the
//   registered busy output.

`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      busy
);

  localparam int IDX_W         = $clog2(DEPTH);
  localparam int CNT_W         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int TAG_WRITE_BIT = 12;

  // FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQACK  = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_WACK    = 3'd3;
  localparam logic [2:0] S_WCOMMIT = 3'd4;
  localparam logic [2:0] S_RWAIT   = 3'd5;
  localparam logic [2:0] S_RBEAT   = 3'd6;

  logic [2:0] state;
  logic [2:0] state_next;

  // Line storage: word 0 of a line is the least significant 64 bits.
  logic [7:0][BUS_DATA_WIDTH-1:0] mem [DEPTH];
  logic [7:0][BUS_DATA_WIDTH-1:0] wbuf;

  logic [IDX_W-1:0]         line_q;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic [2:0]               start_word;
  logic [2:0]               ptr;
  logic [CNT_W-1:0]         lat_cnt;

  logic                      is_write;
  logic [2:0]                next_word;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  // Address bits that select nothing in this build are folded here on purpose.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bus_req;

`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
  logic [2:0] crit_q;

  // Critical word offset, captured with the address beat
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus_reqcyc) begin
      crit_q <= bus_req[5:3];
    end
  end

  assign start_word = crit_q;
`else
  assign start_word = 3'd0;
`endif

  assign is_write = (tag_q[TAG_WRITE_BIT] == `SYSBUS_WRITE);

  // Word to present on the next response beat: the first word when leaving
  // RWAIT, or the following word when the current beat is consumed.
  assign next_word = (state == S_RBEAT) ? (start_word + ptr + 3'd1) : start_word;
  assign rd_word   = mem[line_q][next_word];

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus_reqcyc) begin
          state_next = S_REQACK;
        end
      end
      S_REQACK: begin
        state_next = is_write ? S_WDATA : S_RWAIT;
      end
      S_WDATA: begin
        if (bus_reqcyc) begin
          state_next = S_WACK;
        end
      end
      S_WACK: begin
        state_next = (ptr == 3'd7) ? S_WCOMMIT : S_WDATA;
      end
      S_WCOMMIT: begin
        state_next = S_IDLE;
      end
      S_RWAIT: begin
        if (lat_cnt == '0) begin
          state_next = S_RBEAT;
        end
      end
      S_RBEAT: begin
        if (bus_respack && ptr == 3'd7) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control state, beat pointer, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= 3'd0;
      lat_cnt     <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      bus_reqack  <= (state_next == S_REQACK) || (state_next == S_WACK);
      bus_respcyc <= (state_next == S_RBEAT);
      busy        <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus_reqcyc) begin
            ptr <= 3'd0;
          end
        end
        S_REQACK: begin
          if (!is_write) begin
            lat_cnt <= CNT_W'(READ_LATENCY - 1);
          end
        end
        S_WACK: begin
          if (ptr != 3'd7) begin
            ptr <= ptr + 3'd1;
          end
        end
        S_RWAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end else begin
            ptr         <= 3'd0;
            bus_resp    <= rd_word;
            bus_resptag <= tag_q;
          end
        end
        S_RBEAT: begin
          if (bus_respack && ptr != 3'd7) begin
            ptr      <= ptr + 3'd1;
            bus_resp <= rd_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Request capture: line index and tag with the address beat
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus_reqcyc) begin
      line_q <= bus_req[6 +: IDX_W];
      tag_q  <= bus_reqtag;
    end
  end

  // Write buffer fill, one word per accepted data beat
  always_ff @(posedge clk) begin
    if (state == S_WDATA && bus_reqcyc) begin
      wbuf[ptr] <= bus_req;
    end
  end

  // Whole-line commit; a reset before this point discards the buffer
  always_ff @(posedge clk) begin
    if (!reset && state == S_WCOMMIT) begin
      mem[line_q] <= wbuf;
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder
//   Scenario tasks drive the bus, push expected read beats into exp_q from a
//   line model, and compare the collected response beats in order.
`timescale 1ns/1ps

module tb_sysbus_mem_responder;

  localparam int RL    = 4;
  localparam int DEPTH = 256;
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
  localparam logic [2:0] CWF_MASK = 3'b111;
`else
  localparam logic [2:0] CWF_MASK = 3'b000;
`endif

  // clock / reset
  logic        clk;
  logic        reset;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        busy;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .DEPTH         (DEPTH),
    .READ_LATENCY  (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_reqack (bus_reqack),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and bookkeeping
  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [7:0][63:0] model_mem [int];

  // results of the last bus_read
  logic [63:0] got_w [8];
  logic [12:0] got_t [8];
  int          got_lat;
  int          got_stall_err;
  bit          got_timeout;
  logic        post_respcyc;
  logic        post_busy;

  function automatic int idx_of(input logic [63:0] a);
    return int'(a[13:6]);
  endfunction

  function automatic logic [2:0] start_of(input logic [63:0] a);
    return a[5:3] & CWF_MASK;
  endfunction

  function automatic logic [7:0][63:0] rand_line();
    logic [7:0][63:0] l;
    for (int i = 0; i < 8; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  // push the 8 expected beats of a read of addr
  task automatic push_expected(input logic [63:0] addr);
    logic [7:0][63:0] l;
    logic [2:0] w;
    l = model_mem[idx_of(addr)];
    for (int i = 0; i < 8; i++) begin
      w = start_of(addr) + 3'(i);
      exp_q.push_back(l[w]);
    end
  endtask

  // driver: present one request beat and wait (bounded) for its ack
  task automatic send_beat(input logic [63:0] value, input logic [12:0] tag, output bit ok);
    bus_reqcyc = 1'b1;
    bus_req    = value;
    bus_reqtag = tag;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus_reqack) ok = 1'b1;
    end
  endtask

  // driver: address beat plus n_data write beats; returns number of acks
  task automatic bus_write(input logic [63:0] addr, input logic [7:0][63:0] line,
                           input int n_data, output int acks);
    bit ok;
    acks = 0;
    send_beat(addr, 13'h1000 | 13'($urandom_range(0, 4095)), ok);
    if (ok) begin
      acks++;
      for (int i = 0; i < n_data; i++) begin
        send_beat(line[i], 13'h0, ok);
        if (!ok) break;
        acks++;
      end
    end
    bus_reqcyc = 1'b0;
    bus_req    = 64'h0;
  endtask

  // driver: read burst, optionally withholding respack on one beat
  task automatic bus_read(input logic [63:0] addr, input logic [12:0] tag,
                          input int stall_beat, input int stall_cycles);
    bit ok;
    int beats, stalled, guard;
    int unsigned ack_cyc;
    logic [63:0] held_w;
    logic [12:0] held_t;
    for (int i = 0; i < 8; i++) begin
      got_w[i] = 'x;
      got_t[i] = 'x;
    end
    got_lat = -1;
    got_stall_err = 0;
    got_timeout = 1'b0;
    send_beat(addr, tag, ok);
    bus_reqcyc = 1'b0;
    bus_req    = 64'h0;
    if (!ok) begin
      got_timeout = 1'b1;
      return;
    end
    ack_cyc = cyc;
    beats = 0;
    stalled = 0;
    guard = 0;
    held_w = '0;
    held_t = '0;
    while (beats < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      bus_respack = 1'b0;
      if (bus_respcyc) begin
        if (got_lat < 0) got_lat = int'(cyc - ack_cyc);
        if (stalled > 0 && beats == stall_beat &&
            (bus_resp !== held_w || bus_resptag !== held_t)) got_stall_err++;
        if (beats == stall_beat && stalled < stall_cycles) begin
          held_w = bus_resp;
          held_t = bus_resptag;
          stalled++;
        end else begin
          got_w[beats] = bus_resp;
          got_t[beats] = bus_resptag;
          bus_respack = 1'b1;
          beats++;
        end
      end
    end
    if (beats < 8) got_timeout = 1'b1;
    @(negedge clk);
    bus_respack  = 1'b0;
    post_respcyc = bus_respcyc;
    post_busy    = busy;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = 64'h0;
    bus_reqtag  = 13'h0;
    bus_respack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: reqack=%b respcyc=%b busy=%b expected 0/0/0",
               bus_reqack, bus_respcyc, busy);
    end
    tests_run++;
    if (bus_resp !== 64'h0 || bus_resptag !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_data: resp=%h resptag=%h expected 0/0", bus_resp, bus_resptag);
    end
  endtask

  // write 0x11..0x88 to 0x1040, read back, check order, tag and latency
  task automatic test_write_read();
    logic [7:0][63:0] l;
    logic [63:0] e;
    int acks;
    for (int i = 0; i < 8; i++) l[i] = 64'(8'h11 * (i + 1));
    bus_write(64'h1040, l, 8, acks);
    tests_run++;
    if (acks !== 9) begin
      tests_failed++;
      $display("FAIL write_acks: got %0d expected 9", acks);
    end
    model_mem[idx_of(64'h1040)] = l;
    push_expected(64'h1040);
    bus_read(64'h1040, 13'h0155, 8, 0);
    tests_run++;
    if (got_timeout) begin
      tests_failed++;
      $display("FAIL wr_rd_timeout: read burst did not complete");
    end
    tests_run++;
    if (got_lat !== RL + 1) begin
      tests_failed++;
      $display("FAIL read_latency: ack->first beat got %0d cycles expected %0d", got_lat, RL + 1);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_w[i] !== e || got_t[i] !== 13'h0155) begin
        tests_failed++;
        $display("FAIL wr_rd beat%0d: got %h tag %h expected %h tag 0155", i, got_w[i], got_t[i], e);
      end
    end
    tests_run++;
    if (post_respcyc !== 1'b0 || post_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_end: respcyc=%b busy=%b expected 0/0", post_respcyc, post_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    push_expected(64'h1040);
    bus_read(64'h1040, 13'h0a0a, 3, 5);
    tests_run++;
    if (got_timeout || got_stall_err != 0) begin
      tests_failed++;
      $display("FAIL bp_stable: timeout=%0d unstable_cycles=%0d expected 0/0", got_timeout, got_stall_err);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_w[i] !== e || got_t[i] !== 13'h0a0a) begin
        tests_failed++;
        $display("FAIL bp beat%0d: got %h tag %h expected %h tag 0a0a", i, got_w[i], got_t[i], e);
      end
    end
  endtask

  task automatic test_critical_word();
    logic [63:0] e;
    logic [63:0] first_exp;
    first_exp = (CWF_MASK != 3'b000) ? 64'h44 : 64'h11;
    push_expected(64'h1058);
    bus_read(64'h1058, 13'h0042, 8, 0);
    tests_run++;
    if (got_w[0] !== first_exp) begin
      tests_failed++;
      $display("FAIL cwf_first: got %h expected %h", got_w[0], first_exp);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_w[i] !== e) begin
        tests_failed++;
        $display("FAIL cwf beat%0d: got %h expected %h", i, got_w[i], e);
      end
    end
  endtask

  // reset after 4 write data beats must leave the stored line unchanged
  task automatic test_abort();
    logic [7:0][63:0] l;
    logic [63:0] e;
    int acks;
    l = rand_line();
    bus_write(64'h2000, l, 8, acks);
    model_mem[idx_of(64'h2000)] = l;
    tests_run++;
    if (acks !== 9) begin
      tests_failed++;
      $display("FAIL abort_setup_acks: got %0d expected 9", acks);
    end
    bus_write(64'h2000, rand_line(), 4, acks);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (acks !== 5 || busy !== 1'b0 || bus_reqack !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: acks=%0d busy=%b reqack=%b expected 5/0/0", acks, busy, bus_reqack);
    end
    push_expected(64'h2000);
    bus_read(64'h2000, 13'h0777, 8, 0);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_w[i] !== e) begin
        tests_failed++;
        $display("FAIL abort beat%0d: got %h expected %h", i, got_w[i], e);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int seen, guard;
    logic [63:0] e;
    send_beat(64'h1040, 13'h0123, ok);
    bus_reqcyc = 1'b0;
    seen = 0;
    guard = 0;
    while (ok && seen < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      bus_respack = 1'b0;
      if (bus_respcyc) begin
        bus_respack = 1'b1;
        seen++;
      end
    end
    tests_run++;
    if (!ok || seen < 2) begin
      tests_failed++;
      $display("FAIL midrst_setup: ack=%0d beats_seen=%0d expected 1/2", ok, seen);
    end
    bus_respack = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_respcyc !== 1'b0 || bus_reqack !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_state: respcyc=%b reqack=%b busy=%b expected 0/0/0",
               bus_respcyc, bus_reqack, busy);
    end
    push_expected(64'h1040);
    bus_read(64'h1040, 13'h0321, 8, 0);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_w[i] !== e || got_t[i] !== 13'h0321) begin
        tests_failed++;
        $display("FAIL midrst beat%0d: got %h tag %h expected %h tag 0321", i, got_w[i], got_t[i], e);
      end
    end
  endtask

  task automatic test_ignored_respack();
    bus_respack = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_respcyc !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_respack: respcyc=%b busy=%b expected 0/0", bus_respcyc, busy);
    end
    bus_respack = 1'b0;
  endtask

  // write immediately followed by a read of the same line through an aliased address
  task automatic test_back_to_back();
    logic [7:0][63:0] l;
    logic [63:0] wa, ra, e;
    logic [12:0] tag;
    int acks;
    for (int n = 0; n < 4; n++) begin
      l  = rand_line();
      wa = {$urandom, $urandom};
      ra = {$urandom, $urandom};
      ra[13:6] = wa[13:6];
      tag = 13'($urandom_range(0, 4095));
      bus_write(wa, l, 8, acks);
      tests_run++;
      if (acks !== 9) begin
        tests_failed++;
        $display("FAIL b2b%0d_acks: got %0d expected 9", n, acks);
      end
      model_mem[idx_of(wa)] = l;
      push_expected(ra);
      bus_read(ra, tag, 8, 0);
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front();
        tests_run++;
        if (got_w[i] !== e || got_t[i] !== tag) begin
          tests_failed++;
          $display("FAIL b2b%0d beat%0d: got %h tag %h expected %h tag %h", n, i, got_w[i], got_t[i], e, tag);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_critical_word();
    test_abort();
    test_reset_mid_burst();
    test_ignored_respack();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
